// File: rtl/gemm_pipeline.sv
// Free-running 32x32 unsigned integer matrix multiplier, C = A x B mod 2^32.
// Three register stages: operand capture, two 16-term partial sums, final add.
module gemm_pipeline (
    input  logic           clk,
    input  logic           rst,
    input  logic [32767:0] arg0,
    input  logic [32767:0] arg1,
    output logic [32767:0] out
);

    localparam int N = 32;
    localparam int W = 32;
    localparam int H = N / 2;

    // Row-major element views: index i*N+j holds element [i][j].
    logic [N*N-1:0][W-1:0] a_q;
    logic [N*N-1:0][W-1:0] b_q;
    logic [N*N-1:0][W-1:0] p_lo_d;
    logic [N*N-1:0][W-1:0] p_hi_d;
    logic [N*N-1:0][W-1:0] p_lo_q;
    logic [N*N-1:0][W-1:0] p_hi_q;
    logic [N*N-1:0][W-1:0] c_d;

    // Splitting the dot product into k<16 and k>=16 halves bounds the
    // multiply-accumulate depth of the critical stage to 16 terms.
    always_comb begin
        p_lo_d = '0;
        p_hi_d = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < H; k++) begin
                    p_lo_d[10'(i*N+j)] = p_lo_d[10'(i*N+j)]
                        + a_q[10'(i*N+k)] * b_q[10'(k*N+j)];
                    p_hi_d[10'(i*N+j)] = p_hi_d[10'(i*N+j)]
                        + a_q[10'(i*N+k+H)] * b_q[10'((k+H)*N+j)];
                end
            end
        end
    end

    always_comb begin
        c_d = '0;
        for (int e = 0; e < N*N; e++) begin
            c_d[10'(e)] = p_lo_q[10'(e)] + p_hi_q[10'(e)];
        end
    end

    // Every stage loads each cycle; reset zeroes the whole pipe so no
    // in-flight result survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            p_lo_q <= '0;
            p_hi_q <= '0;
            out    <= '0;
        end else begin
            a_q    <= arg0;
            b_q    <= arg1;
            p_lo_q <= p_lo_d;
            p_hi_q <= p_hi_d;
            out    <= c_d;
        end
    end

endmodule

// File: tb/tb_gemm_pipeline.sv
// Bench for gemm_pipeline: constant-expectation table, reset sequences and a
// randomized back-to-back stream checked against a plain-arithmetic model.
module tb_gemm_pipeline;

    typedef logic [32767:0] mat_t;

    typedef struct {
        string name;
        mat_t  a;
        mat_t  b;
        mat_t  exp;
    } vec_t;

    logic clk;
    logic rst;
    mat_t arg0;
    mat_t arg1;
    mat_t out;

    int n_cmp;
    int n_bad;

    vec_t vecs[6];
    mat_t exp_q[$];

    gemm_pipeline dut (
        .clk  (clk),
        .rst  (rst),
        .arg0 (arg0),
        .arg1 (arg1),
        .out  (out)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic mat_t set_el(mat_t m, int i, int j, logic [31:0] v);
        mat_t r;
        r = m;
        r[15'((i*32+j)*32) +: 32] = v;
        return r;
    endfunction

    function automatic mat_t fill(logic [31:0] v);
        mat_t r;
        for (int e = 0; e < 1024; e++) r[15'(e*32) +: 32] = v;
        return r;
    endfunction

    function automatic mat_t ident();
        mat_t r;
        r = '0;
        for (int i = 0; i < 32; i++) r = set_el(r, i, i, 32'd1);
        return r;
    endfunction

    function automatic mat_t rand_mat();
        mat_t r;
        for (int e = 0; e < 1024; e++) r[15'(e*32) +: 32] = $urandom;
        return r;
    endfunction

    // Reference: exact dot product in wide arithmetic, reduced mod 2^32 at the end.
    function automatic mat_t golden(mat_t a, mat_t b);
        logic [31:0]     ea[32][32];
        logic [31:0]     eb[32][32];
        longint unsigned acc;
        mat_t            c;
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) begin
                ea[i][j] = a[15'((i*32+j)*32) +: 32];
                eb[i][j] = b[15'((i*32+j)*32) +: 32];
            end
        c = '0;
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) begin
                acc = 0;
                for (int k = 0; k < 32; k++)
                    acc += longint'(ea[i][k]) * longint'(eb[k][j]);
                c[15'((i*32+j)*32) +: 32] = acc[31:0];
            end
        return c;
    endfunction

    // scoreboard compare
    task automatic check_mat(string name, mat_t exp);
        int first;
        int nd;
        n_cmp++;
        if (out !== exp) begin
            n_bad++;
            first = -1;
            nd = 0;
            for (int e = 0; e < 1024; e++)
                if (out[15'(e*32) +: 32] !== exp[15'(e*32) +: 32]) begin
                    nd++;
                    if (first < 0) first = e;
                end
            $display("FAIL %s: %0d elements differ, first [%0d][%0d] got %h expected %h",
                     name, nd, first / 32, first % 32,
                     out[15'(first*32) +: 32], exp[15'(first*32) +: 32]);
        end
    endtask

    // driver
    task automatic drive(mat_t a, mat_t b);
        arg0 = a;
        arg1 = b;
    endtask

    initial begin
        mat_t ramp;
        mat_t ar;
        mat_t m;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        drive('0, '0);

        ramp = '0;
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) ramp = set_el(ramp, i, j, 32'(i*32 + j));
        ar = rand_mat();

        vecs[0] = '{"identity_a", ident(), ramp, ramp};
        vecs[1] = '{"identity_b", ar, ident(), ar};
        vecs[2] = '{"wrap_single", set_el('0, 0, 0, 32'hFFFF_FFFF),
                    set_el('0, 0, 0, 32'd2), set_el('0, 0, 0, 32'hFFFF_FFFE)};
        vecs[3] = '{"wrap_2p16", fill(32'h0001_0000), fill(32'h0001_0000), '0};
        vecs[4] = '{"wrap_all_ones", fill(32'hFFFF_FFFF), fill(32'hFFFF_FFFF), fill(32'd32)};
        vecs[5] = '{"zero", '0, fill(32'h1234_5678), '0};

        tick();
        check_mat("reset_state", '0);
        tick();
        rst = 1'b0;

        // table-driven vectors, each held for the 3-cycle latency
        foreach (vecs[v]) begin
            drive(vecs[v].a, vecs[v].b);
            tick(); tick(); tick();
            check_mat(vecs[v].name, vecs[v].exp);
        end

        // 2x2 corner with a 2-cycle reset pulse while inputs are held
        m = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) m = set_el(m, i, j, 32'd1);
        drive(m, m << 1);
        rst = 1'b1;
        tick();
        check_mat("two_by_two_in_reset", '0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        m = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) m = set_el(m, i, j, 32'd4);
        check_mat("two_by_two", m);

        // back-to-back random stream: pair n must appear 3 edges after it is driven
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 8) begin
                ar = rand_mat();
                m  = rand_mat();
                drive(ar, m);
                exp_q.push_back(golden(ar, m));
            end
            tick();
            if (cyc >= 2) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL stream: expected queue empty at cycle %0d", cyc);
                end else begin
                    check_mat($sformatf("stream_%0d", cyc - 2), exp_q.pop_front());
                end
            end
        end

        // reset mid-flight: nothing queued before reset may reach out
        for (int p = 0; p < 3; p++) begin
            drive(rand_mat(), rand_mat());
            tick();
        end
        rst = 1'b1;
        drive('0, '0);
        tick();
        check_mat("midflight_rst_edge", '0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_mat($sformatf("midflight_flush_%0d", c), '0);
        end

        // reset held with non-zero inputs
        drive(rand_mat(), rand_mat());
        tick(); tick(); tick();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_mat($sformatf("rst_hold_%0d", c), '0);
        end
        rst = 1'b0;

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gemm_pipeline.md
# gemm_pipeline

Fully pipelined 32×32 integer matrix multiplier computing C = A × B on unsigned 32-bit elements with modulo-2^32 arithmetic. The block accepts one full matrix pair per clock and produces one full result matrix per clock after a fixed 3-cycle latency. It has no handshake: it is a free-running datapath stage inside a larger compute pipeline, and the consumer tracks validity by latency.

## Interface
Parameters: none. The dimension is fixed at N = 32 and the element width at W = 32.

Ports:
- clk  input  1  — single clock; all state updates on the rising edge.
- rst  input  1  — reset; synchronous and active-high; clears all pipeline registers.
- arg0  input  32768  — matrix A, 1024 elements of 32 bits, row-major.
- arg1  input  32768  — matrix B, same layout as arg0.
- out  output  32768  — matrix C, same layout; driven directly from a register.

Element layout, shared by all three buses:
- Element [i][j] occupies bits (i*32 + j)*32 + 31 down to (i*32 + j)*32.
- Examples: A[0][0] = arg0[31:0], A[0][1] = arg0[63:32], A[1][0] = arg0[1055:1024], A[1][1] = arg0[1087:1056].

## Operation
- Computes C[i][j] = Σ_{k=0..31} A[i][k]·B[k][j] for all i, j in 0..31.
- Arithmetic rules:
  - Operands are unsigned.
  - Each product keeps only its low 32 bits.
  - Every addition wraps modulo 2^32.
  - No saturation and no overflow flag.
  - The result equals the exact mathematical sum taken mod 2^32.
- Pipeline structure, three register stages:
  - S1: register arg0 and arg1 unchanged.
  - S2: from S1, compute per element two 32-bit partial sums, P_lo over k=0..15 and P_hi over k=16..31, and register them.
  - S3: out register receives P_lo + P_hi (mod 2^32).
- No control logic, FSM or valid signal. Every stage loads on every clock when rst = 0.
- Reset behaviour:
  - While rst = 1 at a rising edge, S1, S2 and the out register all load 0.
  - out therefore reads 0 from the first edge with rst high.
  - This matches the natural result of multiplying zero matrices.
- Reset mid-operation flushes all in-flight results; none survives reset.

## Timing
- Latency: inputs sampled at rising edge n appear on out after edge n+2, i.e. 3 register stages.
- Throughput: one independent matrix pair per cycle; back-to-back inputs give back-to-back outputs with no bubbles.
- After rst deasserts, with inputs held constant:
  - The first clean edge loads S1.
  - The third clean edge makes out valid.
  - Before that, out is 0 or reflects partially flushed zero data.
- Inputs may change every cycle. Only the value present at the sampling edge matters.
- Recommended critical path: the 16-term multiply-accumulate in S2.

## Test plan
- 2×2 corner case: A[0][0], A[0][1], A[1][0], A[1][1] = 1 and B at the same four positions = 2, all other elements 0. Hold inputs, pulse rst for 2 cycles, wait ≥3 cycles. Required: C[0][0], C[0][1], C[1][0], C[1][1] = 4, all other 1020 elements = 0.
- Identity: A = I, B[i][j] = i*32 + j. Required: C = B exactly. Repeat with B = I, A arbitrary; required: C = A.
- Wrap-around:
  - A[0][0] = 0xFFFFFFFF, B[0][0] = 2, rest 0. Required: C[0][0] = 0xFFFFFFFE.
  - All A and B elements = 0x00010000. Required: every C element = 0, since 32·2^32 ≡ 0.
  - All elements = 0xFFFFFFFF. Required: every C element = 32 (0x20).
- Latency and throughput: apply a distinct random pair on each of 8 consecutive cycles. Required: out on cycle n+3 equals the golden product of pair n for every n, with no gaps.
- Reset mid-flight: stream 3 pairs, assert rst for 1 cycle, then apply zero matrices.
  - Required: out = 0 from the edge where rst is sampled high.
  - Required: none of the 3 pre-reset results ever appears on out.
- Reset value: hold rst = 1 with arbitrary non-zero inputs for 5 cycles. Required: out = 0 throughout.
